// File: rtl/ysyx_2022040010_ifu_if.sv
// Fetch-unit bundle: pipeline control, instruction-memory request/response and decode output.
interface ysyx_2022040010_ifu_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INST_W = 32
);
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   flush_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  // The fetch unit itself
  modport master (
    input  stall, flush, flush_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst
  );

  // Pipeline control, instruction memory and decode seen from the outside
  modport slave (
    output stall, flush, flush_pc, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/ysyx_2022040010_ifu.sv
// Instruction fetch unit: issues sequential fetches into a small in-order buffer,
// fills entries from in-order memory responses, and drops stale responses after a redirect.
module ysyx_2022040010_ifu #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_START = 64'h0000_0000_8000_0000
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_2022040010_ifu_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q;
  logic [CW-1:0]     occ_q, out_q, drop_q, drop_d;
  logic [PW-1:0]     head_q, tail_q, fill_q;
  logic [DEPTH-1:0]  filled_q;
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic req_valid_c, out_valid_c, fire_c, pop_c, fill_c;
  logic unused_flush_lsb;

  // Low address bits of the redirect target are forced to zero
  assign unused_flush_lsb = ^bus.flush_pc[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next state, handshake valids and drop-count update
  always_comb begin
    state_d     = state_q;
    req_valid_c = 1'b0;
    out_valid_c = 1'b0;
    drop_d      = drop_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        req_valid_c = !bus.stall && !bus.flush && (occ_q != CW'(DEPTH));
        out_valid_c = !bus.stall && !bus.flush && (occ_q != '0) && filled_q[head_q];
        if (bus.flush) begin
          drop_d  = out_q - CW'(bus.imem_resp_valid && (out_q != '0));
          state_d = (drop_d != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (bus.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        state_d = (drop_d != '0) ? DRAIN : RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  assign fire_c = req_valid_c && bus.imem_req_ready;
  assign pop_c  = out_valid_c && bus.out_ready;
  assign fill_c = (state_q == RUN) && !bus.flush && bus.imem_resp_valid && (out_q != '0);

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_c;
  assign bus.out_pc         = pc_mem[head_q];
  assign bus.out_inst       = inst_mem[head_q];

  // PC, fetch buffer and bookkeeping counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_START;
      occ_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      filled_q <= '0;
      pc_mem   <= '{default: '0};
      inst_mem <= '{default: '0};
    end else begin
      drop_q <= drop_d;
      if (bus.flush) begin
        pc_q     <= {bus.flush_pc[XLEN-1:2], 2'b00};
        occ_q    <= '0;
        out_q    <= '0;
        head_q   <= '0;
        tail_q   <= '0;
        fill_q   <= '0;
        filled_q <= '0;
      end else begin
        if (fire_c) begin
          pc_mem[tail_q]   <= pc_q;
          filled_q[tail_q] <= 1'b0;
          tail_q           <= tail_q + PW'(1);
          pc_q             <= pc_q + XLEN'(4);
        end
        if (fill_c) begin
          inst_mem[fill_q] <= bus.imem_resp_data;
          filled_q[fill_q] <= 1'b1;
          fill_q           <= fill_q + PW'(1);
        end
        if (pop_c) head_q <= head_q + PW'(1);
        occ_q <= occ_q + CW'(fire_c) - CW'(pop_c);
        out_q <= out_q + CW'(fire_c) - CW'(fill_c);
      end
    end
  end

endmodule
